// File: rtl/fifo_pkg.sv
// fifo_pkg: shared mode constants and pointer helpers for the flagged FIFO
package fifo_pkg;
  localparam int FIFO_MODE_STD = 0;
  localparam int FIFO_MODE_FWFT = 1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
  function automatic int ptr_inc(input int ptr, input int d);
    return (ptr == d - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port W x D storage, registered or combinational read
module fifo_mem import fifo_pkg::*; #(
  parameter int W = 8,
  parameter int D = 256,
  parameter int AW = clog2(D),
  parameter int FWFT = FIFO_MODE_STD
) (
  input  logic          clk_i,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [D];
  // write port, no reset so the array can map onto RAM
  always_ff @(posedge clk_i) if (we_i) mem_q[waddr_i] <= wdata_i;
  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign rdata_o = mem_q[raddr_i];
  end else begin : g_std
    logic [W-1:0] rdata_q;
    // output register loads on an accepted read, zeroed by reset/flush
    always_ff @(posedge clk_i)
      if (clr_i) rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
    assign rdata_o = rdata_q;
  end
endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with level, threshold and sticky error flags
module sync_fifo_flags import fifo_pkg::*; #(
  parameter int W = 8,
  parameter int D = 256,
  parameter int AF_THRESH = D - 4,
  parameter int AE_THRESH = 4,
  parameter int FWFT = FIFO_MODE_STD
) (
  input  logic                  system_clk,
  input  logic                  system_reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  write_req,
  input  logic [W-1:0]          fifo_dataIn,
  input  logic                  read_req,
  output logic [W-1:0]          fifo_dataOut,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [clog2(D+1)-1:0] level,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int AW = clog2(D);
  localparam int LW = clog2(D + 1);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  logic rd_ok, wr_ok, flush;
  logic [W-1:0] rdata;
  assign flush = system_reset | clear;
  assign empty = level_q == '0;
  assign full = level_q == LW'(D);
  assign almost_full = level_q >= LW'(AF_THRESH);
  assign almost_empty = level_q <= LW'(AE_THRESH);
  assign level = level_q;
  assign overflow = overflow_q;
  assign underflow = underflow_q;
  // accept qualification; a write at full rides on a same-cycle read
  always_comb begin
    rd_ok = enable & read_req & ~empty;
    wr_ok = enable & write_req & (~full | rd_ok);
    wr_ptr_d = wr_ok ? AW'(ptr_inc(int'(wr_ptr_q), D)) : wr_ptr_q;
    rd_ptr_d = rd_ok ? AW'(ptr_inc(int'(rd_ptr_q), D)) : rd_ptr_q;
    level_d = level_q + LW'(wr_ok) - LW'(rd_ok);
    overflow_d = overflow_q | (enable & write_req & ~wr_ok);
    underflow_d = underflow_q | (enable & read_req & ~rd_ok);
  end
  // state register; reset and flush discard everything
  always_ff @(posedge system_clk)
    if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      overflow_q <= overflow_d;
      underflow_q <= underflow_d;
    end
  fifo_mem #(.W(W), .D(D), .AW(AW), .FWFT(FWFT)) u_mem (
    .clk_i(system_clk),
    .clr_i(flush),
    .we_i(wr_ok & ~flush),
    .waddr_i(wr_ptr_q),
    .wdata_i(fifo_dataIn),
    .re_i(rd_ok & ~flush),
    .raddr_i(rd_ptr_q),
    .rdata_o(rdata)
  );
  assign fifo_dataOut = (FWFT == FIFO_MODE_FWFT && empty) ? '0 : rdata;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed scoreboard bench for standard and FWFT FIFOs
module tb_sync_fifo_flags;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 1, en = 0, clr = 0, wr = 0, rd = 0;
  logic [7:0] din = 0, dout;
  logic emp, ful, af, ae, ovf, unf;
  logic [2:0] lvl;
  logic f_rst = 1, f_wr = 0, f_rd = 0;
  logic [7:0] f_din = 0, f_dout;
  logic f_emp, f_ful, f_af, f_ae, f_ovf, f_unf;
  logic [2:0] f_lvl;
  int total = 0, passed = 0;
  logic [7:0] q[$];
  logic [7:0] fq[$];
  logic [7:0] exp_dout = 0;
  bit m_ovf = 0, m_unf = 0, f_movf = 0, f_munf = 0;

  sync_fifo_flags #(.W(8), .D(6), .AF_THRESH(5), .AE_THRESH(1), .FWFT(0)) dut (
    .system_clk(clk), .system_reset(rst), .enable(en), .clear(clr),
    .write_req(wr), .fifo_dataIn(din), .read_req(rd), .fifo_dataOut(dout),
    .empty(emp), .full(ful), .almost_full(af), .almost_empty(ae),
    .level(lvl), .overflow(ovf), .underflow(unf)
  );
  sync_fifo_flags #(.W(8), .D(4), .AF_THRESH(3), .AE_THRESH(0), .FWFT(1)) dut_f (
    .system_clk(clk), .system_reset(f_rst), .enable(1'b1), .clear(1'b0),
    .write_req(f_wr), .fifo_dataIn(f_din), .read_req(f_rd), .fifo_dataOut(f_dout),
    .empty(f_emp), .full(f_ful), .almost_full(f_af), .almost_empty(f_ae),
    .level(f_lvl), .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input bit r, input bit c, input bit e, input bit w,
                      input logic [7:0] d, input bit rr, input string tag);
    bit rok, wok;
    int sz;
    rst = r; clr = c; en = e; wr = w; din = d; rd = rr;
    rok = e && rr && q.size() != 0;
    wok = e && w && (q.size() < 6 || rok);
    if (r || c) begin
      q.delete(); m_ovf = 0; m_unf = 0; exp_dout = 0;
    end else begin
      if (e && w && !wok) m_ovf = 1;
      if (e && rr && !rok) m_unf = 1;
      if (rok) exp_dout = q.pop_front();
      if (wok) q.push_back(d);
    end
    @(posedge clk); #1;
    sz = q.size();
    chk({tag, ".level"}, 32'(lvl), 32'(sz));
    chk({tag, ".data"}, 32'(dout), 32'(exp_dout));
    chk({tag, ".flags"}, 32'({emp, ful, af, ae, ovf, unf}),
        32'({sz == 0, sz == 6, sz >= 5, sz <= 1, m_ovf, m_unf}));
  endtask

  task automatic fstep(input bit r, input bit w, input logic [7:0] d, input bit rr,
                       input string tag);
    bit rok, wok;
    int sz;
    f_rst = r; f_wr = w; f_din = d; f_rd = rr;
    rok = rr && fq.size() != 0;
    wok = w && (fq.size() < 4 || rok);
    if (r) begin
      fq.delete(); f_movf = 0; f_munf = 0;
    end else begin
      if (w && !wok) f_movf = 1;
      if (rr && !rok) f_munf = 1;
      if (rok) void'(fq.pop_front());
      if (wok) fq.push_back(d);
    end
    @(posedge clk); #1;
    sz = fq.size();
    chk({tag, ".level"}, 32'(f_lvl), 32'(sz));
    chk({tag, ".data"}, 32'(f_dout), sz != 0 ? 32'(fq[0]) : 32'h0);
    chk({tag, ".flags"}, 32'({f_emp, f_ful, f_af, f_ae, f_ovf, f_unf}),
        32'({sz == 0, sz == 4, sz >= 3, sz == 0, f_movf, f_munf}));
  endtask

  initial begin
    step(1, 0, 1, 0, 8'h00, 0, "reset");
    step(1, 0, 1, 1, 8'hEE, 1, "reset_req");
    step(0, 0, 1, 0, 8'h00, 0, "idle");
    for (int i = 1; i <= 6; i++) step(0, 0, 1, 1, 8'(i), 0, "fill");
    step(0, 0, 1, 1, 8'h07, 0, "wr_full");
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 8'h00, 1, "drain");
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 8'(8'h10 + i), 0, "refill");
    for (int i = 0; i < 10; i++) step(0, 0, 1, 1, 8'(8'hA0 + i), 1, "rw_full");
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 8'h00, 1, "drain_wrap");
    step(0, 1, 1, 0, 8'h00, 0, "clear1");
    step(0, 0, 1, 1, 8'h55, 1, "rw_empty");
    step(0, 1, 1, 0, 8'h00, 0, "clear2");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 8'(8'h21 + i), 0, "pre_dis");
    step(0, 0, 1, 0, 8'h00, 1, "rd_en");
    for (int i = 0; i < 6; i++) step(0, 0, 0, i[0], 8'(8'h90 + i), !i[0], "disabled");
    step(0, 0, 1, 1, 8'h99, 1, "burst");
    step(1, 0, 1, 1, 8'hEE, 1, "rst_mid");
    step(0, 0, 1, 1, 8'h42, 0, "post_wr");
    step(0, 0, 1, 0, 8'h00, 1, "post_rd");
    step(0, 0, 0, 0, 8'h00, 0, "park");
    fstep(1, 0, 8'h00, 0, "f_reset");
    fstep(0, 1, 8'h3C, 0, "f_wr");
    fstep(0, 0, 8'h00, 0, "f_hold");
    fstep(0, 1, 8'h77, 0, "f_wr2");
    fstep(0, 0, 8'h00, 1, "f_rd1");
    fstep(0, 0, 8'h00, 1, "f_rd2");
    fstep(0, 0, 8'h00, 1, "f_rd_empty");
    for (int i = 0; i < 5; i++) fstep(0, 1, 8'(8'hC0 + i), 0, "f_fill");
    fstep(0, 1, 8'hD0, 1, "f_rw_full");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
